// File: rtl/bus_seq_pkg.sv
// Shared types for the bus scenario sequencer: FSM state encoding and the
// per-step scenario descriptor, plus a constructor used by the scenario table.
package bus_seq_pkg;

  localparam int SEQ_NUM_MASTERS = 2;
  localparam int SEQ_ADDR_W      = 14;
  localparam int SEQ_DATA_W      = 8;
  localparam int SEQ_BURST_W     = 3;
  localparam int SEQ_SCEN_W      = 5;
  localparam int SEQ_MAX_STEPS   = 8;
  localparam int SEQ_STEP_W      = $clog2(SEQ_MAX_STEPS);
  localparam int GAP_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic                       last;
    logic [SEQ_NUM_MASTERS-1:0] mask;
    logic                       read;
    logic [SEQ_BURST_W-1:0]     burst;
    logic [SEQ_ADDR_W-1:0]      addr;
    logic [SEQ_DATA_W-1:0]      data;
    logic [GAP_W-1:0]           gap;
  } step_desc_t;

  function automatic step_desc_t mk_desc(
    input logic                       last,
    input logic [SEQ_NUM_MASTERS-1:0] mask,
    input logic                       read,
    input logic [SEQ_BURST_W-1:0]     burst,
    input logic [SEQ_ADDR_W-1:0]      addr,
    input logic [SEQ_DATA_W-1:0]      data,
    input logic [GAP_W-1:0]           gap
  );
    step_desc_t d;
    d.last  = last;
    d.mask  = mask;
    d.read  = read;
    d.burst = burst;
    d.addr  = addr;
    d.data  = data;
    d.gap   = gap;
    return d;
  endfunction

endpackage

// File: rtl/scenario_rom.sv
// Combinational scenario table: {scenario, step} -> step descriptor.
// Unprogrammed entries end the scenario immediately without driving any master.
module scenario_rom
  import bus_seq_pkg::*;
(
  input  logic [SEQ_SCEN_W-1:0] scen,
  input  logic [SEQ_STEP_W-1:0] step,
  output step_desc_t            desc
);

  always_comb begin
    desc = mk_desc(1'b1, '0, 1'b0, '0, '0, '0, '0);
    case ({scen, step})
      {5'd1, 3'd0}: desc = mk_desc(1'b1, 2'b01, 1'b0, 3'd0, 14'd1001,  8'd212, 8'd0);
      {5'd2, 3'd0}: desc = mk_desc(1'b0, 2'b00, 1'b0, 3'd0, 14'd0,     8'd0,   8'd2);
      {5'd2, 3'd1}: desc = mk_desc(1'b1, 2'b11, 1'b0, 3'd7, 14'd16383, 8'd255, 8'd0);
      {5'd3, 3'd0}: desc = mk_desc(1'b0, 2'b01, 1'b1, 3'd2, 14'd5012,  8'd0,   8'd0);
      {5'd3, 3'd1}: desc = mk_desc(1'b1, 2'b10, 1'b1, 3'd5, 14'd1001,  8'd0,   8'd8);
      {5'd7, 3'd0}: desc = mk_desc(1'b1, 2'b11, 1'b0, 3'd0, 14'd5097,  8'd102, 8'd0);
      default: ;
    endcase
    // Scenario 4 never sets last, so it runs until the step index saturates.
    if (scen == 5'd4) desc = mk_desc(1'b0, 2'b00, 1'b0, 3'd0, 14'd0, 8'd0, 8'd1);
  end

endmodule

// File: rtl/bus_scenario_sequencer.sv
// Replays stored multi-step scenarios onto NUM_MASTERS command ports; all outputs registered.
// Each step waits for masked requests to drop; a stuck request aborts the scenario after TIMEOUT cycles.
module bus_scenario_sequencer
  import bus_seq_pkg::*;
#(
  parameter int NUM_MASTERS   = SEQ_NUM_MASTERS,
  parameter int ADDR_W        = SEQ_ADDR_W,
  parameter int DATA_W        = SEQ_DATA_W,
  parameter int BURST_W       = SEQ_BURST_W,
  parameter int SCEN_W        = SEQ_SCEN_W,
  parameter int MAX_STEPS     = SEQ_MAX_STEPS,
  parameter int ENABLE_CYCLES = 3,
  parameter int TIMEOUT       = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [SCEN_W-1:0]              scenario_sel,
  input  logic [NUM_MASTERS-1:0]         m_request,
  output logic [NUM_MASTERS-1:0]         m_enable,
  output logic [NUM_MASTERS-1:0]         m_read_en,
  output logic [NUM_MASTERS*BURST_W-1:0] m_burst_mode,
  output logic [NUM_MASTERS*DATA_W-1:0]  m_data,
  output logic [NUM_MASTERS*ADDR_W-1:0]  m_addr,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout_err,
  output logic [2:0]                     state_out,
  output logic [$clog2(MAX_STEPS)-1:0]   step_out
);

  localparam int STEP_W  = $clog2(MAX_STEPS);
  localparam int CNT_MAX = (TIMEOUT > 255) ? ((TIMEOUT > ENABLE_CYCLES) ? TIMEOUT : ENABLE_CYCLES)
                                           : ((ENABLE_CYCLES > 255) ? ENABLE_CYCLES : 255);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e            state, state_d;
  logic [SCEN_W-1:0] scen_q;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              tmo_d;
  logic              adv;
  step_desc_t        rom_desc, desc_q, desc_src;
  logic              issue_entry, bus_clear;

  scenario_rom u_rom (
    .scen (scen_q),
    .step (step_q),
    .desc (rom_desc)
  );

  // In LOAD the descriptor register is still being written, so decisions use the ROM directly.
  assign desc_src = (state == ST_LOAD) ? rom_desc : desc_q;

  always_comb begin
    state_d = state;
    step_d  = step_q;
    cnt_d   = cnt + CNT_W'(1);
    tmo_d   = timeout_err;
    adv     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = ST_LOAD;
          step_d  = '0;
          tmo_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        cnt_d = '0;
        if (rom_desc.gap != '0)       state_d = ST_GAP;
        else if (rom_desc.mask != '0) state_d = ST_ISSUE;
        else                          adv     = 1'b1;
      end
      ST_GAP: begin
        if (cnt == CNT_W'(desc_q.gap) - CNT_W'(1)) begin
          cnt_d = '0;
          if (desc_q.mask != '0) state_d = ST_ISSUE;
          else                   adv     = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (cnt == CNT_W'(ENABLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if ((m_request & desc_q.mask) == '0) begin
          adv = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (adv) begin
      cnt_d = '0;
      if (desc_src.last || step_q == STEP_W'(MAX_STEPS - 1)) begin
        state_d = ST_DONE;
      end else begin
        step_d  = step_q + STEP_W'(1);
        state_d = ST_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      scen_q      <= '0;
      step_q      <= '0;
      cnt         <= '0;
      desc_q      <= '0;
      timeout_err <= 1'b0;
      m_enable    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_d;
      step_q      <= step_d;
      cnt         <= cnt_d;
      timeout_err <= tmo_d;
      if (state == ST_IDLE && start) scen_q <= scenario_sel;
      if (state == ST_LOAD)          desc_q <= rom_desc;
      m_enable <= (state_d == ST_ISSUE) ? desc_src.mask : '0;
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_DONE);
    end
  end

  assign state_out = state;
  assign step_out  = step_q;

  // Command fields latch on ISSUE entry and persist through WAIT.
  assign issue_entry = (state_d == ST_ISSUE) && (state != ST_ISSUE);
  assign bus_clear   = (state_d == ST_IDLE) || (state_d == ST_DONE);

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
    logic               rd_r;
    logic [BURST_W-1:0] burst_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [DATA_W-1:0]  data_r;

    always_ff @(posedge clk) begin
      if (reset || bus_clear) begin
        rd_r    <= 1'b0;
        burst_r <= '0;
        addr_r  <= '0;
        data_r  <= '0;
      end else if (issue_entry) begin
        rd_r    <= desc_src.mask[i] ? desc_src.read : 1'b0;
        burst_r <= desc_src.mask[i] ? desc_src.burst : '0;
        addr_r  <= desc_src.mask[i] ? desc_src.addr + ADDR_W'(i) : '0;
        data_r  <= desc_src.mask[i] ? desc_src.data + DATA_W'(i) : '0;
      end
    end

    assign m_read_en[i]                    = rd_r;
    assign m_burst_mode[i*BURST_W +: BURST_W] = burst_r;
    assign m_addr[i*ADDR_W +: ADDR_W]      = addr_r;
    assign m_data[i*DATA_W +: DATA_W]      = data_r;
  end

endmodule

// File: tb/tb_bus_scenario_sequencer.sv
// Bench for bus_scenario_sequencer: per-cycle expected trace built from the scenario rules,
// reactive master model with configurable request hold time.
module tb_bus_scenario_sequencer;

  localparam int NM  = 2;
  localparam int AW  = 14;
  localparam int DW  = 8;
  localparam int BW  = 3;
  localparam int SW  = 5;
  localparam int MS  = 8;
  localparam int STW = 3;
  localparam int EC  = 3;
  localparam int TO  = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [SW-1:0]     scenario_sel = '0;
  logic [NM-1:0]     m_request;
  logic [NM-1:0]     m_enable, m_read_en;
  logic [NM*BW-1:0]  m_burst_mode;
  logic [NM*DW-1:0]  m_data;
  logic [NM*AW-1:0]  m_addr;
  logic              busy, done, timeout_err;
  logic [2:0]        state_out;
  logic [STW-1:0]    step_out;

  always #5 clk = ~clk;

  bus_scenario_sequencer #(
    .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .SCEN_W(SW),
    .MAX_STEPS(MS), .ENABLE_CYCLES(EC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .scenario_sel(scenario_sel),
    .m_request(m_request), .m_enable(m_enable), .m_read_en(m_read_en),
    .m_burst_mode(m_burst_mode), .m_data(m_data), .m_addr(m_addr),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .state_out(state_out), .step_out(step_out)
  );

  int vectors = 0;
  int miscompares = 0;

  // Master model: request rises while enabled and stays up for hold_cfg cycles after enable falls.
  int            hold_cfg = 0;
  logic [NM-1:0] noise = '0;
  logic [NM-1:0] req = '0;
  int            rem[NM];

  initial begin
    m_request = '0;
    for (int i = 0; i < NM; i++) rem[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NM; i++) begin
        if (m_enable[i]) begin
          rem[i] = hold_cfg;
          req[i] = 1'b1;
        end else if (rem[i] > 0) begin
          rem[i]--;
        end else begin
          req[i] = 1'b0;
        end
      end
      m_request = req | noise;
    end
  end

  typedef struct {
    bit            last;
    bit [NM-1:0]   mask;
    bit            rd;
    int            burst, addr, data, gap;
  } stp_t;

  typedef struct {
    int            st, step;
    bit [NM-1:0]   en;
    bit            busy, done, tmo, chk;
    logic [NM*AW-1:0] addr;
    logic [NM*DW-1:0] data;
    logic [NM-1:0]    rd;
    logic [NM*BW-1:0] burst;
  } exp_t;

  exp_t q[$];

  function automatic stp_t scen_step(int sc, int s);
    stp_t t = '{1, 2'b00, 0, 0, 0, 0, 0};
    case (sc)
      1: if (s == 0) t = '{1, 2'b01, 0, 0, 1001, 212, 0};
      2: if (s == 0) t = '{0, 2'b00, 0, 0, 0, 0, 2};
         else if (s == 1) t = '{1, 2'b11, 0, 7, 16383, 255, 0};
      3: if (s == 0) t = '{0, 2'b01, 1, 2, 5012, 0, 0};
         else if (s == 1) t = '{1, 2'b10, 1, 5, 1001, 0, 8};
      4: t = '{0, 2'b00, 0, 0, 0, 0, 1};
      7: if (s == 0) t = '{1, 2'b11, 0, 0, 5097, 102, 0};
      default: ;
    endcase
    return t;
  endfunction

  function automatic exp_t mk(int st, int stp, bit [NM-1:0] en, bit tmo, bit chk, stp_t t, bit [NM-1:0] m);
    exp_t e;
    e.st = st; e.step = stp; e.en = en; e.busy = (st != 0); e.done = (st == 5);
    e.tmo = tmo; e.chk = chk;
    e.addr = '0; e.data = '0; e.rd = '0; e.burst = '0;
    for (int i = 0; i < NM; i++) begin
      if (m[i]) begin
        e.addr[i*AW +: AW]  = AW'(t.addr + i);
        e.data[i*DW +: DW]  = DW'(t.data + i);
        e.rd[i]             = t.rd;
        e.burst[i*BW +: BW] = BW'(t.burst);
      end
    end
    return e;
  endfunction

  // Expected trace, one entry per cycle after the start edge.
  task automatic build(int sc, int hold);
    stp_t t;
    bit   abort;
    int   last_s, wait_n;
    q.delete();
    abort = 1'b0;
    last_s = 0;
    for (int s = 0; s < MS; s++) begin
      t = scen_step(sc, s);
      last_s = s;
      q.push_back(mk(1, s, '0, 1'b0, 1'b0, t, '0));
      for (int g = 0; g < t.gap; g++) q.push_back(mk(2, s, '0, 1'b0, 1'b0, t, '0));
      if (t.mask != '0) begin
        for (int c = 0; c < EC; c++) q.push_back(mk(3, s, t.mask, 1'b0, 1'b1, t, t.mask));
        abort  = (hold >= TO);
        wait_n = abort ? TO : hold + 1;
        for (int w = 0; w < wait_n; w++) q.push_back(mk(4, s, '0, 1'b0, 1'b1, t, t.mask));
      end
      if (abort || t.last) break;
    end
    q.push_back(mk(5, last_s, '0, abort, 1'b1, t, '0));
    q.push_back(mk(0, last_s, '0, abort, 1'b1, t, '0));
  endtask

  task automatic run_scenario(string name, int sc, int hold, logic [NM-1:0] nz, bit spurious);
    exp_t e;
    build(sc, hold);
    hold_cfg = hold;
    noise = nz;
    @(negedge clk);
    start = 1'b1;
    scenario_sel = SW'(sc);
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      start = (spurious && k < q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      scenario_sel = SW'($urandom);
      e = q[k];
      vectors++;
      if ({state_out, step_out, m_enable, busy, done, timeout_err} !==
          {3'(e.st), STW'(e.step), e.en, e.busy, e.done, e.tmo}) begin
        miscompares++;
        $display("FAIL %s scen%0d cyc%0d ctrl: got st=%0d step=%0d en=%b busy=%b done=%b tmo=%b, want st=%0d step=%0d en=%b busy=%b done=%b tmo=%b",
                 name, sc, k, state_out, step_out, m_enable, busy, done, timeout_err,
                 e.st, e.step, e.en, e.busy, e.done, e.tmo);
      end
      if (e.chk) begin
        vectors++;
        if ({m_read_en, m_burst_mode, m_addr, m_data} !== {e.rd, e.burst, e.addr, e.data}) begin
          miscompares++;
          $display("FAIL %s scen%0d cyc%0d bus: got rd=%b burst=%h addr=%h data=%h, want rd=%b burst=%h addr=%h data=%h",
                   name, sc, k, m_read_en, m_burst_mode, m_addr, m_data, e.rd, e.burst, e.addr, e.data);
        end
      end
    end
    noise = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_enable, m_read_en, m_burst_mode, m_data, m_addr, busy, done, timeout_err, state_out, step_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got en=%b st=%0d step=%0d busy=%b done=%b tmo=%b addr=%h data=%h, want all 0",
               m_enable, state_out, step_out, busy, done, timeout_err, m_addr, m_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_master();
    run_scenario("single", 1, 2, 2'b10, 1'b1);
  endtask

  task automatic test_dual_master();
    run_scenario("dual", 7, int'($urandom_range(0, 4)), '0, 1'b1);
  endtask

  task automatic test_gap_steps();
    run_scenario("gap", 3, 1, '0, 1'b0);
  endtask

  task automatic test_timeout();
    run_scenario("near_timeout", 1, TO - 1, '0, 1'b0);
    run_scenario("timeout", 3, 300, '0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vectors++;
      if (timeout_err !== 1'b1 || state_out !== 3'd0) begin
        miscompares++;
        $display("FAIL timeout_sticky: got tmo=%b st=%0d, want tmo=1 st=0", timeout_err, state_out);
      end
    end
  endtask

  task automatic test_wrap_and_skip();
    run_scenario("wrap_skip", 2, 0, '0, 1'b0);
  endtask

  task automatic test_max_steps();
    run_scenario("max_steps", 4, 0, '0, 1'b1);
  endtask

  task automatic test_unprogrammed();
    run_scenario("unprog", 31, 0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    hold_cfg = 2;
    @(negedge clk);
    start = 1'b1;
    scenario_sel = SW'(7);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_enable !== 2'b11 || state_out !== 3'd3) begin
      miscompares++;
      $display("FAIL reset_mid_issue: got en=%b st=%0d, want en=11 st=3", m_enable, state_out);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    vectors++;
    if ({m_enable, m_read_en, m_burst_mode, m_data, m_addr, busy, done, timeout_err, state_out, step_out} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_clear: got en=%b st=%0d busy=%b done=%b addr=%h data=%h, want all 0",
               m_enable, state_out, busy, done, m_addr, m_data);
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || state_out !== 3'd0) begin
        miscompares++;
        $display("FAIL reset_mid_quiet: got done=%b busy=%b st=%0d, want 0 0 0", done, busy, state_out);
      end
    end
    run_scenario("after_reset", 7, 1, '0, 1'b0);
  endtask

  task automatic test_random();
    int tbl[6] = '{1, 2, 3, 4, 7, 31};
    int sc, hold;
    for (int n = 0; n < 16; n++) begin
      sc   = ($urandom_range(0, 7) < 6) ? tbl[$urandom_range(0, 5)] : int'($urandom_range(0, 31));
      hold = ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 6));
      run_scenario("random", sc, hold, '0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_dual_master();
    test_gap_steps();
    test_timeout();
    test_wrap_and_skip();
    test_max_steps();
    test_unprogrammed();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
